decode_stage: RTL and testbench

Decode/register-file stage of the pipelined Y-86 core, directly downstream of fetch. It consumes fetch's 145-bit D bus, reads and forwards operands, and holds the 15×64 architectural register file written by writeback. It registers the results into the E pipeline register consumed by execute, with stall and bubble control from the hazard unit.

---
 rtl/decode_stage.sv | 189 ++++++++++++++++++
 tb/tb_decode_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Y-86 decode/register-file stage: source/destination selection, operand forwarding,
// the 15 x 64 architectural register file and the E pipeline register.
module decode_stage (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [144:0] D,
  input  logic         E_stall,
  input  logic         E_bubble,
  input  logic [3:0]   e_dstE,
  input  logic [3:0]   M_dstE,
  input  logic [3:0]   M_dstM,
  input  logic [3:0]   W_dstE,
  input  logic [3:0]   W_dstM,
  input  logic [63:0]  e_valE,
  input  logic [63:0]  M_valE,
  input  logic [63:0]  m_valM,
  input  logic [63:0]  W_valE,
  input  logic [63:0]  W_valM,
  output logic [3:0]   d_srcA,
  output logic [3:0]   d_srcB,
  output logic [2:0]   E_stat,
  output logic [3:0]   E_icode,
  output logic [3:0]   E_ifun,
  output logic [63:0]  E_valC,
  output logic [63:0]  E_valA,
  output logic [63:0]  E_valB,
  output logic [3:0]   E_dstE,
  output logic [3:0]   E_dstM,
  output logic [3:0]   E_srcA,
  output logic [3:0]   E_srcB
);

  localparam logic [3:0] IcodeHalt   = 4'h0;
  localparam logic [3:0] IcodeNop    = 4'h1;
  localparam logic [3:0] IcodeRrmovq = 4'h2;
  localparam logic [3:0] IcodeIrmovq = 4'h3;
  localparam logic [3:0] IcodeRmmovq = 4'h4;
  localparam logic [3:0] IcodeMrmovq = 4'h5;
  localparam logic [3:0] IcodeOpq    = 4'h6;
  localparam logic [3:0] IcodeJxx    = 4'h7;
  localparam logic [3:0] IcodeCall   = 4'h8;
  localparam logic [3:0] IcodeRet    = 4'h9;
  localparam logic [3:0] IcodePushq  = 4'hA;
  localparam logic [3:0] IcodePopq   = 4'hB;

  localparam logic [3:0] RegRsp  = 4'h4;
  localparam logic [3:0] RegNone = 4'hF;

  localparam logic [2:0] StatAok = 3'd1;
  localparam logic [2:0] StatHlt = 3'd2;
  localparam logic [2:0] StatAdr = 3'd3;
  localparam logic [2:0] StatIns = 3'd4;

  localparam int unsigned NumRegs = 15;

  logic        w_imem_error;
  logic [3:0]  w_icode;
  logic [3:0]  w_ifun;
  logic [3:0]  w_ra;
  logic [3:0]  w_rb;
  logic [63:0] w_valc;
  logic [63:0] w_valp;

  assign w_imem_error = D[144];
  assign w_icode      = D[143:140];
  assign w_ifun       = D[139:136];
  assign w_ra         = D[135:132];
  assign w_rb         = D[131:128];
  assign w_valc       = D[127:64];
  assign w_valp       = D[63:0];

  logic [3:0]  w_dste;
  logic [3:0]  w_dstm;
  logic [2:0]  w_stat;
  logic [63:0] w_rf_a;
  logic [63:0] w_rf_b;
  logic [63:0] w_vala;
  logic [63:0] w_valb;

  logic [63:0] r_rf [NumRegs];

  always_comb begin
    d_srcA = RegNone;
    unique case (w_icode)
      IcodeRrmovq, IcodeRmmovq, IcodeOpq, IcodePushq: d_srcA = w_ra;
      IcodeRet, IcodePopq:                            d_srcA = RegRsp;
      default:                                        d_srcA = RegNone;
    endcase
  end

  always_comb begin
    d_srcB = RegNone;
    unique case (w_icode)
      IcodeRmmovq, IcodeMrmovq, IcodeOpq:            d_srcB = w_rb;
      IcodeCall, IcodeRet, IcodePushq, IcodePopq:    d_srcB = RegRsp;
      default:                                       d_srcB = RegNone;
    endcase
  end

  always_comb begin
    w_dste = RegNone;
    unique case (w_icode)
      IcodeRrmovq, IcodeIrmovq, IcodeOpq:            w_dste = w_rb;
      IcodeCall, IcodeRet, IcodePushq, IcodePopq:    w_dste = RegRsp;
      default:                                       w_dste = RegNone;
    endcase
  end

  assign w_dstm = (w_icode == IcodeMrmovq || w_icode == IcodePopq) ? w_ra : RegNone;

  always_comb begin
    w_stat = StatAok;
    if (w_imem_error)            w_stat = StatAdr;
    else if (w_icode > IcodePopq) w_stat = StatIns;
    else if (w_icode == IcodeHalt) w_stat = StatHlt;
  end

  // Index F is not a register; reads of it return zero.
  assign w_rf_a = (d_srcA == RegNone) ? 64'd0 : r_rf[d_srcA];
  assign w_rf_b = (d_srcB == RegNone) ? 64'd0 : r_rf[d_srcB];

  // Youngest producer wins; a source of F never matches any destination.
  function automatic logic [63:0] fwd(input logic [3:0] src, input logic [63:0] rf_val);
    logic [63:0] v;
    v = rf_val;
    if (src == RegNone)     v = 64'd0;
    else if (src == e_dstE) v = e_valE;
    else if (src == M_dstM) v = m_valM;
    else if (src == M_dstE) v = M_valE;
    else if (src == W_dstM) v = W_valM;
    else if (src == W_dstE) v = W_valE;
    return v;
  endfunction

  always_comb begin
    w_vala = fwd(d_srcA, w_rf_a);
    if (w_icode == IcodeJxx || w_icode == IcodeCall) w_vala = w_valp;
  end

  assign w_valb = fwd(d_srcB, w_rf_b);

  // The M write is issued last so it takes precedence when both ports hit one index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumRegs; i++) r_rf[i] <= 64'd0;
    end else begin
      if (W_dstE != RegNone) r_rf[W_dstE] <= W_valE;
      if (W_dstM != RegNone) r_rf[W_dstM] <= W_valM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      E_stat  <= StatAok;
      E_icode <= IcodeNop;
      E_ifun  <= 4'h0;
      E_valC  <= 64'd0;
      E_valA  <= 64'd0;
      E_valB  <= 64'd0;
      E_dstE  <= RegNone;
      E_dstM  <= RegNone;
      E_srcA  <= RegNone;
      E_srcB  <= RegNone;
    end else if (E_bubble) begin
      E_stat  <= StatAok;
      E_icode <= IcodeNop;
      E_ifun  <= 4'h0;
      E_valC  <= 64'd0;
      E_valA  <= 64'd0;
      E_valB  <= 64'd0;
      E_dstE  <= RegNone;
      E_dstM  <= RegNone;
      E_srcA  <= RegNone;
      E_srcB  <= RegNone;
    end else if (!E_stall) begin
      E_stat  <= w_stat;
      E_icode <= w_icode;
      E_ifun  <= w_ifun;
      E_valC  <= w_valc;
      E_valA  <= w_vala;
      E_valB  <= w_valb;
      E_dstE  <= w_dste;
      E_dstM  <= w_dstm;
      E_srcA  <= d_srcA;
      E_srcB  <= d_srcB;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Randomised and directed bench for decode_stage against a behavioural model of the
// decode rules, forwarding priority, register file and E register.
module tb_decode_stage;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [144:0] D;
  logic         E_stall, E_bubble;
  logic [3:0]   e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0]  e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [3:0]   d_srcA, d_srcB;
  logic [2:0]   E_stat;
  logic [3:0]   E_icode, E_ifun;
  logic [63:0]  E_valC, E_valA, E_valB;
  logic [3:0]   E_dstE, E_dstM, E_srcA, E_srcB;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .D(D), .E_stall(E_stall), .E_bubble(E_bubble),
    .e_dstE(e_dstE), .M_dstE(M_dstE), .M_dstM(M_dstM), .W_dstE(W_dstE), .W_dstM(W_dstM),
    .e_valE(e_valE), .M_valE(M_valE), .m_valM(m_valM), .W_valE(W_valE), .W_valM(W_valM),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM),
    .E_srcA(E_srcA), .E_srcB(E_srcB)
  );

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode, ifun;
    logic [63:0] valc, vala, valb;
    logic [3:0]  dste, dstm, srca, srcb;
  } e_t;

  e_t          exp_e;
  logic [63:0] m_rf [16];
  int          errors = 0;
  int          checks = 0;
  bit          chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic e_t nop_e();
    e_t r;
    r = '0;
    r.stat = 3'd1; r.icode = 4'h1;
    r.dste = 4'hF; r.dstm = 4'hF; r.srca = 4'hF; r.srcb = 4'hF;
    return r;
  endfunction

  function automatic logic [3:0] m_srca(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
    if (ic inside {4'h9, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_srcb(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  // Operand value as seen by the stage: youngest in-flight producer, else the register file.
  function automatic logic [63:0] m_read(input logic [3:0] src);
    logic [3:0]  fd [5];
    logic [63:0] fv [5];
    if (src == 4'hF) return 64'd0;
    fd = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
    fv = '{e_valE, m_valM, M_valE, W_valM, W_valE};
    for (int i = 0; i < 5; i++) if (fd[i] == src) return fv[i];
    return m_rf[src];
  endfunction

  function automatic e_t m_decode();
    e_t         r;
    logic [3:0] ic;
    ic = D[143:140];
    r.icode = ic;
    r.ifun  = D[139:136];
    r.valc  = D[127:64];
    r.stat  = D[144] ? 3'd3 : (ic > 4'hB) ? 3'd4 : (ic == 4'h0) ? 3'd2 : 3'd1;
    r.srca  = m_srca(ic, D[135:132]);
    r.srcb  = m_srcb(ic, D[131:128]);
    r.dste  = (ic inside {4'h2, 4'h3, 4'h6}) ? D[131:128] :
              (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
    r.dstm  = (ic inside {4'h5, 4'hB}) ? D[135:132] : 4'hF;
    r.vala  = (ic == 4'h7 || ic == 4'h8) ? D[63:0] : m_read(r.srca);
    r.valb  = m_read(r.srcb);
    return r;
  endfunction

  task automatic model_reset();
    exp_e = nop_e();
    for (int i = 0; i < 16; i++) m_rf[i] = 64'd0;
  endtask

  task automatic model_edge();
    e_t nd;
    nd = m_decode();
    if (E_bubble) exp_e = nop_e();
    else if (!E_stall) exp_e = nd;
    if (W_dstE != 4'hF) m_rf[W_dstE] = W_valE;
    if (W_dstM != 4'hF) m_rf[W_dstM] = W_valM;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic set_d(input logic err, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] valc, input logic [63:0] valp);
    D = {err, ic, fn, ra, rb, valc, valp};
  endtask

  task automatic idle_ctl();
    E_stall = 1'b0; E_bubble = 1'b0;
    e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
    e_valE = '0; M_valE = '0; m_valM = '0; W_valE = '0; W_valM = '0;
  endtask

  function automatic logic [3:0] rand_reg();
    if ($urandom_range(0, 3) == 0) return 4'hF;
    if ($urandom_range(0, 1) == 0) return 4'($urandom_range(0, 4));
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic logic [63:0] rand64();
    return {32'($urandom), 32'($urandom)};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("d_srcA", d_srcA, m_srca(D[143:140], D[135:132]));
      chk("d_srcB", d_srcB, m_srcb(D[143:140], D[131:128]));
      chk("E_stat", E_stat, exp_e.stat);
      chk("E_icode", E_icode, exp_e.icode);
      chk("E_ifun", E_ifun, exp_e.ifun);
      chk("E_valC", E_valC, exp_e.valc);
      chk("E_valA", E_valA, exp_e.vala);
      chk("E_valB", E_valB, exp_e.valb);
      chk("E_dstE", E_dstE, exp_e.dste);
      chk("E_dstM", E_dstM, exp_e.dstm);
      chk("E_srcA", E_srcA, exp_e.srca);
      chk("E_srcB", E_srcB, exp_e.srcb);
    end
  end

  initial begin
    idle_ctl();
    set_d(1'b0, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0);
    #1 rst_n = 1'b0;
    model_reset();
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("reset E_icode", E_icode, 64'h1);
    chk("reset E_stat", E_stat, 64'h1);
    chk("reset E_dstE", E_dstE, 64'hF);
    rst_n = 1'b1;

    set_d(1'b0, 4'h3, 4'h0, 4'hF, 4'h2, 64'h55, 64'h0A);
    cycle();
    chk("irmovq E_icode", E_icode, 64'h3);
    chk("irmovq E_valC", E_valC, 64'h55);
    chk("irmovq E_dstE", E_dstE, 64'h2);
    chk("irmovq E_srcA", E_srcA, 64'hF);

    set_d(1'b0, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0);
    W_dstE = 4'h3; W_valE = 64'hAA;
    cycle();
    idle_ctl();
    set_d(1'b0, 4'h2, 4'h0, 4'h3, 4'h1, 64'd0, 64'd0);
    cycle();
    chk("wb-read E_valA", E_valA, 64'hAA);

    set_d(1'b0, 4'h2, 4'h0, 4'h5, 4'h1, 64'd0, 64'd0);
    e_dstE = 4'h5; e_valE = 64'd1;
    M_dstM = 4'h5; m_valM = 64'd2;
    W_dstE = 4'h5; W_valE = 64'd3;
    cycle();
    chk("fwd e", E_valA, 64'd1);
    e_dstE = 4'hF;
    cycle();
    chk("fwd M", E_valA, 64'd2);
    M_dstM = 4'hF;
    cycle();
    chk("fwd W", E_valA, 64'd3);

    idle_ctl();
    set_d(1'b0, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0);
    W_dstE = 4'h4; W_valE = 64'h8; W_dstM = 4'h4; W_valM = 64'h99;
    cycle();
    idle_ctl();
    set_d(1'b0, 4'h2, 4'h0, 4'h4, 4'h1, 64'd0, 64'd0);
    cycle();
    chk("M-over-E write", E_valA, 64'h99);
    set_d(1'b0, 4'hB, 4'h0, 4'h4, 4'hF, 64'd0, 64'h2);
    #1 chk("popq d_srcA", d_srcA, 64'h4);
    cycle();
    chk("popq E_srcA", E_srcA, 64'h4);
    chk("popq E_srcB", E_srcB, 64'h4);
    chk("popq E_dstE", E_dstE, 64'h4);
    chk("popq E_dstM", E_dstM, 64'h4);

    set_d(1'b0, 4'h8, 4'h0, 4'hF, 4'hF, 64'h100, 64'h20);
    cycle();
    chk("call E_valA", E_valA, 64'h20);
    E_stall = 1'b1;
    set_d(1'b0, 4'h3, 4'h0, 4'hF, 4'h6, 64'h77, 64'h0A);
    cycle();
    chk("stall E_icode", E_icode, 64'h8);
    chk("stall E_valA", E_valA, 64'h20);
    E_bubble = 1'b1;
    cycle();
    chk("bubble E_icode", E_icode, 64'h1);
    chk("bubble E_valC", E_valC, 64'h0);
    idle_ctl();

    set_d(1'b1, 4'h3, 4'h0, 4'hF, 4'h2, 64'h1, 64'h2);
    cycle();
    chk("stat ADR", E_stat, 64'd3);
    set_d(1'b0, 4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h2);
    cycle();
    chk("stat INS", E_stat, 64'd4);
    set_d(1'b0, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1);
    cycle();
    chk("stat HLT", E_stat, 64'd2);

    set_d(1'b0, 4'h2, 4'h0, 4'h6, 4'h1, 64'd0, 64'd0);
    W_dstE = 4'h6; W_valE = 64'h77;
    cycle();
    idle_ctl();
    rst_n = 1'b0;
    model_reset();
    #1 chk("async reset E_icode", E_icode, 64'h1);
    chk("async reset E_dstE", E_dstE, 64'hF);
    #1 rst_n = 1'b1;
    cycle();
    chk("reset clears regfile", E_valA, 64'h0);

    for (int n = 0; n < 2000; n++) begin
      set_d(($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            rand_reg(), rand_reg(), rand64(), rand64());
      E_stall  = ($urandom_range(0, 6) == 0);
      E_bubble = ($urandom_range(0, 9) == 0);
      e_dstE = rand_reg(); M_dstE = rand_reg(); M_dstM = rand_reg();
      W_dstE = rand_reg(); W_dstM = rand_reg();
      e_valE = rand64(); M_valE = rand64(); m_valM = rand64();
      W_valE = rand64(); W_valM = rand64();
      cycle();
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
